// File: rtl/fuel_gauge_pkg.sv
// rtl/fuel_gauge_pkg.sv - shared types and constants for the fuel gauge object
package fuel_gauge_pkg;

  localparam int COORD_W = 11;
  localparam int LEVEL_W = 7;

  typedef enum logic [1:0] {IDLE, RUN, EMPTY} fuel_state_t;

  localparam logic [7:0] BAR_GREEN   = 8'h1C;
  localparam logic [7:0] BAR_RED     = 8'hE0;
  localparam logic [7:0] TRANSPARENT = 8'h00;

endpackage

// File: rtl/fuel_level_fsm.sv
// rtl/fuel_level_fsm.sv - fuel level drain/refill counter and IDLE/RUN/EMPTY state machine
module fuel_level_fsm
  import fuel_gauge_pkg::*;
#(
  parameter int FUEL_MAX     = 100,
  parameter int DRAIN_FRAMES = 30,
  parameter int REFILL       = 25,
  parameter int LOW_TH       = 20
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               gameActive,
  input  logic               fuelPickup,
  output logic [LEVEL_W-1:0] fuelLevel,
  output logic               fuelLow,
  output logic               fuelEmpty
);

  localparam int FC_W = $clog2(DRAIN_FRAMES + 1);
  localparam logic [LEVEL_W-1:0] MAX_L = LEVEL_W'(FUEL_MAX);
  localparam logic [LEVEL_W-1:0] LOW_L = LEVEL_W'(LOW_TH);

  fuel_state_t        state, state_nxt;
  logic [FC_W-1:0]    frame_cnt, frame_cnt_nxt;
  logic [LEVEL_W-1:0] level_nxt;
  logic [7:0]         sum;
  logic               drain;

  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    level_nxt     = fuelLevel;
    drain         = 1'b0;
    sum           = '0;
    case (state)
      IDLE: begin
        level_nxt     = MAX_L;
        frame_cnt_nxt = '0;
        if (gameActive) state_nxt = RUN;
      end
      RUN: begin
        if (!gameActive) begin
          state_nxt     = IDLE;
          level_nxt     = MAX_L;
          frame_cnt_nxt = '0;
        end else if (fuelLevel == '0) begin
          state_nxt     = EMPTY;
          frame_cnt_nxt = '0;
        end else begin
          if (startOfFrame) begin
            if (frame_cnt == FC_W'(DRAIN_FRAMES - 1)) begin
              frame_cnt_nxt = '0;
              drain         = 1'b1;
            end else begin
              frame_cnt_nxt = frame_cnt + FC_W'(1);
            end
          end
          // 8-bit sum so a refill near the top saturates instead of wrapping
          sum = {1'b0, fuelLevel} - {7'b0, drain} + (fuelPickup ? 8'(REFILL) : 8'd0);
          level_nxt = (sum > 8'(FUEL_MAX)) ? MAX_L : sum[LEVEL_W-1:0];
        end
      end
      EMPTY: begin
        level_nxt     = '0;
        frame_cnt_nxt = '0;
        if (!gameActive) begin
          state_nxt = IDLE;
          level_nxt = MAX_L;
        end
      end
      default: begin
        state_nxt = IDLE;
        level_nxt = MAX_L;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      frame_cnt <= '0;
      fuelLevel <= MAX_L;
      fuelLow   <= 1'b0;
      fuelEmpty <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_cnt <= frame_cnt_nxt;
      fuelLevel <= level_nxt;
      fuelLow   <= (level_nxt <= LOW_L) && (level_nxt != '0);
      fuelEmpty <= (state_nxt == EMPTY);
    end
  end

endmodule

// File: rtl/fuel_gauge_object.sv
// rtl/fuel_gauge_object.sv - FUEL label offsets plus pipelined level bar; FUEL_BLINK_EN blinks a low bar
module fuel_gauge_object
  import fuel_gauge_pkg::*;
#(
  parameter int TOP_LEFT_X   = 16,
  parameter int TOP_LEFT_Y   = 16,
  parameter int OBJ_W        = 64,
  parameter int OBJ_H        = 16,
  parameter int BAR_GAP      = 4,
  parameter int FUEL_MAX     = 100,
  parameter int DRAIN_FRAMES = 30,
  parameter int REFILL       = 25,
  parameter int LOW_TH       = 20
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  input  logic               startOfFrame,
  input  logic               gameActive,
  input  logic               fuelPickup,
  output logic [COORD_W-1:0] offsetX,
  output logic [COORD_W-1:0] offsetY,
  output logic               InsideRectangle,
  output logic               barDrawingRequest,
  output logic [7:0]         barRGB,
  output logic [LEVEL_W-1:0] fuelLevel,
  output logic               fuelLow,
  output logic               fuelEmpty
);

  localparam int BX = TOP_LEFT_X + OBJ_W + BAR_GAP;
  localparam logic [LEVEL_W-1:0] LOW_L = LEVEL_W'(LOW_TH);
  localparam logic [LEVEL_W-1:0] MAX_L = LEVEL_W'(FUEL_MAX);

  logic [LEVEL_W-1:0] displayLevel;
  logic               row_hit, label_hit, bar_hit, bar_visible;
  logic [COORD_W:0]   bar_end;
  logic [7:0]         bar_rgb_s0, bar_rgb_s1;
  logic               bar_req_s1;

  fuel_level_fsm #(
    .FUEL_MAX    (FUEL_MAX),
    .DRAIN_FRAMES(DRAIN_FRAMES),
    .REFILL      (REFILL),
    .LOW_TH      (LOW_TH)
  ) u_level (
    .clk         (clk),
    .resetN      (resetN),
    .startOfFrame(startOfFrame),
    .gameActive  (gameActive),
    .fuelPickup  (fuelPickup),
    .fuelLevel   (fuelLevel),
    .fuelLow     (fuelLow),
    .fuelEmpty   (fuelEmpty)
  );

  assign row_hit   = (pixelY >= COORD_W'(TOP_LEFT_Y)) && (pixelY < COORD_W'(TOP_LEFT_Y + OBJ_H));
  assign label_hit = row_hit && (pixelX >= COORD_W'(TOP_LEFT_X)) &&
                     (pixelX < COORD_W'(TOP_LEFT_X + OBJ_W));
  assign bar_end   = (COORD_W+1)'(BX) + {{(COORD_W+1-LEVEL_W){1'b0}}, displayLevel};
  assign bar_hit   = row_hit && ({1'b0, pixelX} >= (COORD_W+1)'(BX)) && ({1'b0, pixelX} < bar_end);

`ifdef FUEL_BLINK_EN
  logic [4:0] blink_cnt;
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)           blink_cnt <= '0;
    else if (startOfFrame) blink_cnt <= blink_cnt + 5'd1;
  end
  assign bar_visible = bar_hit && !((displayLevel <= LOW_L) && blink_cnt[4]);
`else
  assign bar_visible = bar_hit;
`endif

  assign bar_rgb_s0 = !bar_visible ? TRANSPARENT : ((displayLevel > LOW_L) ? BAR_GREEN : BAR_RED);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      offsetX           <= '0;
      offsetY           <= '0;
      InsideRectangle   <= 1'b0;
      displayLevel      <= MAX_L;
      bar_req_s1        <= 1'b0;
      bar_rgb_s1        <= TRANSPARENT;
      barDrawingRequest <= 1'b0;
      barRGB            <= TRANSPARENT;
    end else begin
      InsideRectangle <= label_hit;
      offsetX         <= label_hit ? (pixelX - COORD_W'(TOP_LEFT_X)) : '0;
      offsetY         <= label_hit ? (pixelY - COORD_W'(TOP_LEFT_Y)) : '0;
      // latched once per frame so the bar never tears mid-frame
      if (startOfFrame) displayLevel <= fuelLevel;
      // extra stage lines the bar up with the bitmap ROM's registered RGB
      bar_req_s1        <= bar_visible;
      bar_rgb_s1        <= bar_rgb_s0;
      barDrawingRequest <= bar_req_s1;
      barRGB            <= bar_rgb_s1;
    end
  end

endmodule

// File: tb/tb_fuel_gauge_object.sv
// tb/tb_fuel_gauge_object.sv - self-checking bench for fuel_gauge_object against a frame-level model
module tb_fuel_gauge_object;

  localparam int FUEL_MAX = 100;
  localparam int DRAIN    = 30;
  localparam int REFILL   = 25;
  localparam int LOW_TH   = 20;
  localparam int BX       = 84;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [10:0] pixelX = '0;
  logic [10:0] pixelY = '0;
  logic        startOfFrame = 1'b0;
  logic        gameActive = 1'b0;
  logic        fuelPickup = 1'b0;
  logic [10:0] offsetX, offsetY;
  logic        InsideRectangle, barDrawingRequest, fuelLow, fuelEmpty;
  logic [7:0]  barRGB;
  logic [6:0]  fuelLevel;

  always #5 clk = ~clk;

  fuel_gauge_object dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .gameActive(gameActive), .fuelPickup(fuelPickup),
    .offsetX(offsetX), .offsetY(offsetY), .InsideRectangle(InsideRectangle),
    .barDrawingRequest(barDrawingRequest), .barRGB(barRGB), .fuelLevel(fuelLevel),
    .fuelLow(fuelLow), .fuelEmpty(fuelEmpty)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // mode: 0 idle, 1 running, 2 empty
  int m_mode, m_lvl, m_fc, m_disp, m_sofs;
  int e_in, e_ox, e_oy, e_b1_req, e_b1_rgb, e_b2_req, e_b2_rgb;
  int vis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    m_mode = 0; m_lvl = FUEL_MAX; m_fc = 0; m_disp = FUEL_MAX; m_sofs = 0;
    e_in = 0; e_ox = 0; e_oy = 0;
    e_b1_req = 0; e_b1_rgb = 0; e_b2_req = 0; e_b2_rgb = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".inside"}, 32'(InsideRectangle), e_in);
    chk({tag, ".offx"}, 32'(offsetX), e_ox);
    chk({tag, ".offy"}, 32'(offsetY), e_oy);
    chk({tag, ".bar_req"}, 32'(barDrawingRequest), e_b2_req);
    chk({tag, ".bar_rgb"}, 32'(barRGB), e_b2_rgb);
    chk({tag, ".level"}, 32'(fuelLevel), m_lvl);
    chk({tag, ".low"}, 32'(fuelLow), 32'((m_lvl <= LOW_TH) && (m_lvl != 0)));
    chk({tag, ".empty"}, 32'(fuelEmpty), 32'(m_mode == 2));
  endtask

  // one pixel clock: drive inputs, advance the model at the edge, compare on the falling edge
  task automatic cycle(input bit sof, input bit pk, input int px, input int py);
    int s0_req, s0_rgb, nl;
    bit drain;
    startOfFrame = sof; fuelPickup = pk;
    pixelX = 11'(px); pixelY = 11'(py);
    @(posedge clk);
    s0_req = (py >= 16 && py < 32 && px >= BX && px < BX + m_disp) ? 1 : 0;
`ifdef FUEL_BLINK_EN
    if (m_disp <= LOW_TH && (m_sofs % 32) >= 16) s0_req = 0;
`endif
    s0_rgb = (s0_req == 0) ? 0 : ((m_disp > LOW_TH) ? 'h1C : 'hE0);
    e_b2_req = e_b1_req; e_b2_rgb = e_b1_rgb;
    e_b1_req = s0_req;   e_b1_rgb = s0_rgb;
    e_in = (px >= 16 && px < 80 && py >= 16 && py < 32) ? 1 : 0;
    e_ox = e_in ? px - 16 : 0;
    e_oy = e_in ? py - 16 : 0;
    if (sof) begin m_disp = m_lvl; m_sofs++; end
    if (m_mode == 0) begin
      m_lvl = FUEL_MAX; m_fc = 0;
      if (gameActive) m_mode = 1;
    end else if (m_mode == 1) begin
      if (!gameActive) begin
        m_mode = 0; m_lvl = FUEL_MAX; m_fc = 0;
      end else if (m_lvl == 0) begin
        m_mode = 2; m_fc = 0;
      end else begin
        drain = sof && (m_fc == DRAIN - 1);
        if (sof) m_fc = (m_fc + 1) % DRAIN;
        nl = m_lvl - (drain ? 1 : 0) + (pk ? REFILL : 0);
        m_lvl = (nl > FUEL_MAX) ? FUEL_MAX : nl;
      end
    end else begin
      if (!gameActive) begin m_mode = 0; m_lvl = FUEL_MAX; end
      else m_lvl = 0;
    end
    @(negedge clk);
    check_all("cyc");
    startOfFrame = 1'b0; fuelPickup = 1'b0;
  endtask

  task automatic frame(input bit pk);
    cycle(1'b1, pk, $urandom_range(0, 220), $urandom_range(8, 40));
    cycle(1'b0, 1'b0, $urandom_range(0, 220), $urandom_range(8, 40));
    cycle(1'b0, 1'b0, $urandom_range(0, 220), $urandom_range(8, 40));
  endtask

  task automatic run_until(input int target, input int max_frames);
    int n;
    n = 0;
    while (m_lvl != target && n < max_frames) begin
      if (m_lvl < target && m_mode == 1) cycle(1'b0, 1'b1, 0, 0);
      frame(1'b0);
      n++;
    end
    chk($sformatf("reach_level_%0d", target), 32'(fuelLevel), target);
  endtask

  task automatic probe_bar(input int k, input int exp_req, input int exp_rgb, input string tag);
    cycle(1'b0, 1'b0, BX + k, 20);
    cycle(1'b0, 1'b0, 0, 0);
    chk({tag, ".req"}, 32'(barDrawingRequest), exp_req);
    chk({tag, ".rgb"}, 32'(barRGB), exp_rgb);
  endtask

  initial begin
    reset_model();
    #12;
    check_all("reset");
    chk("reset_level", 32'(fuelLevel), 100);
    @(negedge clk);
    resetN = 1'b1;

    // label rectangle corners
    cycle(1'b0, 1'b0, 16, 16);
    chk("lbl_16_16.in", 32'(InsideRectangle), 1);
    chk("lbl_16_16.ox", 32'(offsetX), 0);
    chk("lbl_16_16.oy", 32'(offsetY), 0);
    cycle(1'b0, 1'b0, 80, 31);
    chk("lbl_80_31.in", 32'(InsideRectangle), 0);
    cycle(1'b0, 1'b0, 79, 31);
    chk("lbl_79_31.ox", 32'(offsetX), 63);
    chk("lbl_79_31.oy", 32'(offsetY), 15);
    cycle(1'b0, 1'b1, 0, 0);
    chk("idle_pickup", 32'(fuelLevel), 100);
    for (int i = 0; i < 200; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 220), $urandom_range(0, 40));

    // drain timing
    gameActive = 1'b1;
    cycle(1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 29; i++) frame(1'b0);
    chk("drain_29", 32'(fuelLevel), 100);
    frame(1'b0);
    chk("drain_30", 32'(fuelLevel), 99);

    // refill saturation and combined drain+refill
    run_until(90, 400);
    cycle(1'b0, 1'b1, 0, 0);
    chk("pickup_90", 32'(fuelLevel), 100);
    run_until(40, 2000);
    cycle(1'b0, 1'b1, 0, 0);
    chk("pickup_40", 32'(fuelLevel), 65);
    run_until(40, 800);
    for (int i = 0; i < DRAIN - 1; i++) frame(1'b0);
    chk("pre_combo", 32'(fuelLevel), 40);
    cycle(1'b1, 1'b1, 0, 0);
    chk("combo_40", 32'(fuelLevel), 64);

    // colour threshold and bar length edge
    run_until(21, 1500);
    chk("low_21", 32'(fuelLow), 0);
    frame(1'b0);
    probe_bar(20, 1, 'h1C, "bar21_in");
    probe_bar(21, 0, 0, "bar21_out");
    run_until(20, 40);
    chk("low_20", 32'(fuelLow), 1);
    frame(1'b0);
`ifndef FUEL_BLINK_EN
    probe_bar(19, 1, 'hE0, "bar20_in");
`endif
    probe_bar(20, 0, 0, "bar20_out");

    // low bar over 64 frames: steady, or half visible when blinking
    vis = 0;
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, 1'b0, BX, 20);
      cycle(1'b0, 1'b0, BX, 20);
      cycle(1'b0, 1'b0, BX, 20);
      if (barDrawingRequest === 1'b1) vis++;
    end
`ifdef FUEL_BLINK_EN
    chk("blink_visible", vis, 32);
`else
    chk("steady_visible", vis, 64);
`endif

    // randomized pickups
    for (int i = 0; i < 300; i++) frame(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);

    // leaving RUN reloads full
    run_until(50, 3000);
    gameActive = 1'b0;
    cycle(1'b0, 1'b0, 0, 0);
    chk("drop_run", 32'(fuelLevel), 100);

    // full drain to EMPTY
    gameActive = 1'b1;
    cycle(1'b0, 1'b0, 0, 0);
    run_until(0, 3100);
    cycle(1'b0, 1'b0, 0, 0);
    chk("empty_flag", 32'(fuelEmpty), 1);
    cycle(1'b0, 1'b1, 0, 0);
    chk("empty_pickup", 32'(fuelLevel), 0);
    frame(1'b0);
    probe_bar(0, 0, 0, "bar_empty");
    for (int i = 0; i < 40; i++) frame(1'b1);
    gameActive = 1'b0;
    cycle(1'b0, 1'b0, 0, 0);
    chk("empty_exit", 32'(fuelLevel), 100);

    // asynchronous reset in the middle of a running frame
    gameActive = 1'b1;
    cycle(1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 40; i++) frame(1'b0);
    pixelX = 11'(BX + 2); pixelY = 11'd20;
    #2;
    resetN = 1'b0;
    #1;
    reset_model();
    check_all("async_rst");
    chk("async_rst_level", 32'(fuelLevel), 100);
    @(negedge clk);
    resetN = 1'b1;
    for (int i = 0; i < 20; i++) frame(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fuel_gauge_object.md
Name: fuel_gauge_object

Overview:
Drives the fuel bitmap reader, which is 16 rows x 64 columns with one cycle of ROM latency. It produces the bitmap's pixel offsets and its inside-rectangle strobe. It also owns the player's fuel level: a drain/refill counter with a state machine. It draws a level bar to the right of the "FUEL" label, pipelined so it aligns with the bitmap's RGB output. It sits between the VGA pixel counters and the object mux.

Parameters:
- TOP_LEFT_X, 16, label left edge in pixels.
- TOP_LEFT_Y, 16, label top edge in pixels.
- OBJ_W, 64, label width; must equal the bitmap width.
- OBJ_H, 16, label and bar height.
- BAR_GAP, 4, horizontal gap in pixels between label and bar.
- FUEL_MAX, 100, full level; one bar pixel per unit; max 127.
- DRAIN_FRAMES, 30, frames per one-unit drain.
- REFILL, 25, units added per pickup.
- LOW_TH, 20, fuelLow threshold (inclusive).

Ports:
- clk  in  1  pixel clock.
- resetN  in  1  reset.
- pixelX  in  11  current pixel column.
- pixelY  in  11  current pixel row.
- startOfFrame  in  1  one-cycle pulse per frame.
- gameActive  in  1  level drains while high.
- fuelPickup  in  1  one-cycle pulse; player hit a fuel can.
- offsetX  out  11  column offset to the bitmap.
- offsetY  out  11  row offset to the bitmap.
- InsideRectangle  out  1  pixel is inside the label.
- barDrawingRequest  out  1  bar pixel valid, aligned with the bitmap's RGBout.
- barRGB  out  8  bar colour, RGB332.
- fuelLevel  out  7  live level.
- fuelLow  out  1  fuelLevel <= LOW_TH and fuelLevel != 0.
- fuelEmpty  out  1  high in EMPTY state.

Behaviour:
- Reset is resetN, asynchronous, active-low; clock is clk.
- Reset values:
  - offsetX, offsetY = 0; InsideRectangle = 0.
  - barDrawingRequest = 0; barRGB = 8'h00.
  - fuelLevel = FUEL_MAX; displayLevel = FUEL_MAX; frameCnt = 0.
  - state = IDLE; fuelEmpty = 0; fuelLow = 0.
- Label stage (registered, latency 1 from pixelX/pixelY):
  - inside = pixelX >= TOP_LEFT_X and pixelX < TOP_LEFT_X+OBJ_W, and pixelY >= TOP_LEFT_Y and pixelY < TOP_LEFT_Y+OBJ_H.
  - When inside: offsetX = pixelX-TOP_LEFT_X and offsetY = pixelY-TOP_LEFT_Y. Otherwise both offsets are 0, so no underflow can occur.
- Bar stage (latency 2, matching the bitmap's extra register):
  - BX = TOP_LEFT_X+OBJ_W+BAR_GAP.
  - Bar pixel condition: pixelX >= BX, pixelX < BX+displayLevel, and row inside [TOP_LEFT_Y, TOP_LEFT_Y+OBJ_H).
  - displayLevel = 0 gives no bar pixels.
  - barRGB = 8'h1C (green) if displayLevel > LOW_TH, else 8'hE0 (red).
  - barRGB = 8'h00 whenever barDrawingRequest = 0.
- displayLevel is loaded from fuelLevel only on startOfFrame, so there is no mid-frame tearing.
- FSM states: IDLE, RUN, EMPTY.
  - IDLE: fuelLevel held at FUEL_MAX; frameCnt = 0; pickups ignored. Goes to RUN when gameActive = 1.
  - RUN: on each startOfFrame, frameCnt increments. At DRAIN_FRAMES-1 it wraps to 0 and fuelLevel decrements.
  - RUN pickup: fuelLevel = min(fuelLevel+REFILL, FUEL_MAX). Compute in 8 bits so it saturates with no wrap.
  - RUN, drain and pickup in the same cycle: fuelLevel = min(fuelLevel-1+REFILL, FUEL_MAX).
  - RUN exits: fuelLevel reaching 0 goes to EMPTY on the next clock. gameActive = 0 goes to IDLE, which reloads FUEL_MAX; this takes priority over the EMPTY transition.
  - EMPTY: fuelLevel = 0; fuelEmpty = 1; pickups and drain ignored. Goes to IDLE when gameActive = 0.
- fuelLow and fuelEmpty are registered from next-state values, so they change in the same cycle as fuelLevel.
- An asynchronous reset mid-frame clears the pipeline immediately. The first two pixel cycles after release are invalid (outputs 0).

Optional Feature:
- Macro: FUEL_BLINK_EN.
- Defined:
  - A 5-bit frame counter runs on startOfFrame.
  - While displayLevel <= LOW_TH and bit 4 of that counter = 1, barDrawingRequest is forced to 0. This gives a 16-frames-on / 16-frames-off blink.
  - Label pixels are unaffected.
- Not defined: the low-fuel bar is drawn steadily in red, and the counter is absent.

Decomposition:
- Package fuel_gauge_pkg holds:
  - the state enum {IDLE, RUN, EMPTY};
  - colour constants BAR_GREEN = 8'h1C, BAR_RED = 8'hE0, TRANSPARENT = 8'h00;
  - the coordinate width of 11 and the level width of 7.
- Sub-module fuel_level_fsm holds the FSM, frameCnt, fuelLevel, fuelLow and fuelEmpty.
- The top level holds the rectangle compare, offsets, displayLevel and the 2-stage bar pipeline.

Test Plan:
- Pixel (16,16) at cycle t -> cycle t+1: InsideRectangle = 1, offsetX = 0, offsetY = 0. Pixel (80,31) -> InsideRectangle = 0; (79,31) -> offsets 63,15.
- gameActive = 1 for 30 frames -> fuelLevel 100 to 99. After 3000 frames -> 0, then EMPTY with fuelEmpty = 1; bar absent after the next startOfFrame.
- Pickup at level 90 -> 100 (saturates). Pickup at 40 -> 65. Pickup coinciding with a drain at level 40 -> 64.
- Level 20 -> fuelLow = 1 and bar colour E0. Level 21 -> fuelLow = 0 and colour 1C. Pixel (84+k,20), k < displayLevel, -> barDrawingRequest = 1 at t+2; k = displayLevel -> 0.
- gameActive dropped in RUN at level 50 -> IDLE with level 100. Pickup pulsed in IDLE or EMPTY -> level unchanged.
- resetN asserted mid-frame in RUN -> all outputs 0 and fuelLevel = 100 asynchronously. With FUEL_BLINK_EN at level 10 -> bar visible 16 frames, hidden 16 frames.
